// File: rtl/cache_32x4_mem.sv
// cache_32x4_mem: single-port line-organised memory (4 x 32-bit words per line).
// Byte-addressed within the window [base_addresse, base_addresse + size*16).
// Each request is answered exactly one cycle later. Nothing stalls and nothing
// back-pressures, so a new request may be accepted on every clock.
//
// Handshake: a request is presented when r_v or w_v is high at a rising edge.
// After that edge, resp_valid is high for one cycle with resp/resp_error
// alongside. There is no ready signal, because the memory always accepts.
// If r_v and w_v are both high, the request is a write.
//
// rst_n is an active-high synchronous reset despite its name. It clears only
// the response stage. The storage array keeps its contents.
module cache_32x4_mem #(
    parameter logic [31:0] base_addresse = 32'h0,
    parameter int          size          = 2048,
    parameter int          xlen          = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [xlen-1:0] adr,
    input  logic [xlen-1:0] data,
    input  logic [3:0]      strobe,
    output logic [xlen-1:0] resp,
    output logic            resp_valid,
    output logic            resp_error
);

    localparam int            lw     = (size > 1) ? $clog2(size) : 1;
    // Window length in bytes. It is one bit wider than an address, so that a
    // window reaching the top of the address space still compares correctly.
    localparam logic [xlen:0] window = (xlen + 1)'(size) << 4;

    // Storage. The bench preloads this array through hierarchical access.
    logic [127:0] mem [size-1:0];

    logic [xlen-1:0] offset;
    logic            in_range;
    logic            misaligned;
    logic            acc_error;
    logic [lw-1:0]   line_idx;
    logic [1:0]      word_sel;

    // Decode the byte address into line/word and classify bad accesses
    always_comb begin
        offset     = adr - xlen'(base_addresse);
        in_range   = (adr >= xlen'(base_addresse)) && ({1'b0, offset} < window);
        misaligned = (adr[1:0] != 2'b00);
        acc_error  = !in_range || misaligned;
        line_idx   = offset[4+lw-1:4];
        word_sel   = offset[3:2];
    end

    // Byte-lane write into the selected word. This is blocked while reset is
    // asserted (rst_n high) and for any bad access.
    always_ff @(posedge clk) begin
        if (!rst_n && w_v && !acc_error) begin
            for (int k = 0; k < 4; k++) begin
                if (strobe[k]) begin
                    mem[line_idx][{word_sel, 5'b00000} + 8*k +: 8] <= data[8*k +: 8];
                end
            end
        end
    end

    // Single registered response stage: read data, or zero for writes and errors
    always_ff @(posedge clk) begin
        if (rst_n) begin
            resp       <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
        end else begin
            resp_valid <= r_v || w_v;
            resp_error <= (r_v || w_v) && acc_error;
            if (r_v && !w_v && !acc_error) begin
                resp <= xlen'(mem[line_idx][{word_sel, 5'b00000} +: 32]);
            end else begin
                resp <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cache_32x4_mem.sv
// Testbench for cache_32x4_mem. A byte-array reference model and an expected
// queue are filled by the driver tasks. An independent monitor compares every
// DUT response, including its cycle of arrival, against the queue.
module tb_cache_32x4_mem;

    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          SIZE   = 2048;
    localparam int          NBYTES = SIZE * 16;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        r_v    = 1'b0;
    logic        w_v    = 1'b0;
    logic [31:0] adr    = '0;
    logic [31:0] data   = '0;
    logic [3:0]  strobe = '0;
    logic [31:0] resp;
    logic        resp_valid;
    logic        resp_error;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit mon_en      = 1'b0;

    // Reference model: a flat byte array covering the whole window
    logic [7:0]  model_b [NBYTES];
    // Scoreboard entry layout: {due_cycle[31:0], error, data[31:0]}
    logic [64:0] exp_q[$];

    cache_32x4_mem #(
        .base_addresse(BASE),
        .size         (SIZE),
        .xlen         (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_v       (r_v),
        .w_v       (w_v),
        .adr       (adr),
        .data      (data),
        .strobe    (strobe),
        .resp      (resp),
        .resp_valid(resp_valid),
        .resp_error(resp_error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(NBYTES));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic req(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        logic        err;
        logic [31:0] exp_d;
        int          off;
        @(negedge clk);
        r_v = r; w_v = w; adr = a; data = d; strobe = s;
        if (r || w) begin
            err   = !in_win(a) || (a[1:0] != 2'b00);
            exp_d = '0;
            off   = int'(a - BASE);
            if (!err) begin
                if (w) begin
                    for (int k = 0; k < 4; k++)
                        if (s[k]) model_b[off + k] = d[8*k +: 8];
                end else begin
                    exp_d = {model_b[off + 3], model_b[off + 2], model_b[off + 1], model_b[off]};
                end
            end
            exp_q.push_back({32'(cyc + 1), err, exp_d});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            r_v = 1'b0; w_v = 1'b0;
        end
    endtask

    // One reset cycle that carries a write request. The write must be
    // dropped, and the response that follows must be suppressed.
    task automatic reset_with_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst_n = 1'b1; r_v = 1'b0; w_v = 1'b1; adr = a; data = d; strobe = 4'hF;
        @(negedge clk);
        rst_n = 1'b0; w_v = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [64:0] e;
        if (mon_en) begin
            if (resp_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_resp cyc=%0d got data=%h err=%b, required no response", cyc, resp, resp_error);
                end else begin
                    e = exp_q.pop_front();
                    if (e[64:33] != 32'(cyc) || resp_error !== e[32] || resp !== e[31:0]) begin
                        miscompares++;
                        $display("FAIL resp cyc=%0d got data=%h err=%b, required data=%h err=%b due_cyc=%0d",
                                 cyc, resp, resp_error, e[31:0], e[32], e[64:33]);
                    end
                end
            end else begin
                vectors++;
                if (resp !== 32'h0 || resp_error !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_outputs cyc=%0d got data=%h err=%b, required 0/0", cyc, resp, resp_error);
                end
                if (exp_q.size() > 0 && exp_q[0][64:33] <= 32'(cyc)) begin
                    e = exp_q.pop_front();
                    miscompares++;
                    $display("FAIL missing_resp cyc=%0d got valid=0, required data=%h err=%b", cyc, e[31:0], e[32]);
                end
            end
        end
    end

    // ---------------- preload ----------------
    initial begin
        logic [127:0] line;
        for (int i = 0; i < SIZE; i++) begin
            line = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) line = 128'h44444444_33333333_22222222_11111111;
            if (i == 2) line[31:0] = 32'h0;
            dut.mem[i] = line;
            for (int b = 0; b < 16; b++) model_b[i*16 + b] = line[8*b +: 8];
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          kind;
        // Reset is held for a few cycles, and the monitor checks the cleared outputs
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        // Back-to-back reads of the preloaded line 0
        req(1, 0, BASE + 32'h0, 0, 0);
        req(1, 0, BASE + 32'h4, 0, 0);
        req(1, 0, BASE + 32'hC, 0, 0);
        idle(1);

        // Full write, then single-lane overwrite, then read-after-write
        req(0, 1, BASE + 32'h10, 32'hAABBCCDD, 4'b1111);
        req(0, 1, BASE + 32'h10, 32'h000000EE, 4'b0001);
        req(1, 0, BASE + 32'h10, 0, 0);

        // Middle lanes into a zero word
        req(0, 1, BASE + 32'h20, 32'h12345678, 4'b0110);
        req(1, 0, BASE + 32'h20, 0, 0);
        idle(1);

        // Window boundaries and misalignment
        req(1, 0, BASE - 32'h4, 0, 0);
        req(1, 0, BASE + 32'(NBYTES), 0, 0);
        req(1, 0, BASE + 32'(NBYTES) - 32'h4, 0, 0);
        req(1, 0, BASE + 32'h2, 0, 0);
        req(0, 1, BASE + 32'(NBYTES), 32'hDEADBEEF, 4'hF);
        req(0, 1, BASE - 32'h4, 32'hDEADBEEF, 4'hF);
        req(0, 1, BASE + 32'h31, 32'hDEADBEEF, 4'hF);
        req(1, 0, BASE + 32'h30, 0, 0);

        // Simultaneous read+write acts as a write, and strobe=0 is a no-op write
        req(1, 1, BASE + 32'h50, 32'hCAFEF00D, 4'b1010);
        req(0, 1, BASE + 32'h54, 32'hFFFFFFFF, 4'b0000);
        req(1, 0, BASE + 32'h50, 0, 0);
        req(1, 0, BASE + 32'h54, 0, 0);

        // Continuous read sweep with no bubbles
        for (int i = 0; i < 16; i++) req(1, 0, BASE + 32'(4 * i), 0, 0);

        // Reset mid-stream carrying a write, then the old data is still readable
        req(1, 0, BASE + 32'h40, 0, 0);
        reset_with_write(BASE + 32'h40, 32'h0BADF00D);
        req(1, 0, BASE + 32'h40, 0, 0);
        req(1, 0, BASE + 32'h0, 0, 0);
        idle(2);

        // Randomized mix
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) != 0)
                a = BASE + 32'(4 * $urandom_range(0, 31));
            else
                a = BASE - 32'd64 + 32'($urandom_range(0, NBYTES + 127));
            case (kind)
                0:          idle(1);
                1, 2, 3, 4: req(1, 0, a, 0, 0);
                5, 6, 7, 8: req(0, 1, a, $urandom, 4'($urandom_range(0, 15)));
                default:    req(1, 1, a, $urandom, 4'($urandom_range(0, 15)));
            endcase
        end
        idle(3);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending entries, required 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_32x4_mem.md
# cache_32x4_mem

Single-port, line-organised synchronous memory: each line holds 4 × 32-bit words (128 bits), addressed by byte address within a configurable window. It serves as the CPU's instruction memory (read every cycle) and data memory (byte-strobed reads/writes) in the simulation top level, with one-cycle registered responses and an error flag for bad accesses. The storage array is preloadable by the bench through hierarchical access.

## Interface
Parameters:
- base_addresse, 32'h0, byte address of line 0 word 0.
- size, 2048, number of 128-bit lines.
- xlen, 32, address/data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset. Synchronous, active-high, despite the name.
- r_v  in  1  read request valid.
- w_v  in  1  write request valid.
- adr  in  xlen  byte address of the request.
- data  in  xlen  write data (word-aligned lanes).
- strobe  in  4  byte enables for writes; bit k enables data[8k+7:8k].
- resp  out  xlen  read data.
- resp_valid  out  1  response valid.
- resp_error  out  1  response is an error.

Storage: array named `mem`, `logic [127:0] mem [size-1:0]`; word w of a line is mem[i][32w+31:32w]; byte 0 of the word is bits [7:0] (little-endian). Must remain hierarchically writable from an initial block.

## Operation
- offset = adr − base_addresse (xlen-bit unsigned). In range iff adr ≥ base_addresse and offset < size*16.
- line index = offset[4+$clog2(size)-1:4]; word select = offset[3:2].
- Misaligned iff adr[1:0] ≠ 0. error = !in_range || misaligned.
- Read (r_v=1, w_v=0): no error → resp = selected word, resp_error=0; error → resp=0, resp_error=1. resp_valid=1 either way.
- Write (w_v=1): no error → each byte lane with strobe bit set is written into the selected word at the clock edge; other lanes and words unchanged; resp=0, resp_valid=1, resp_error=0. Error → memory unchanged, resp=0, resp_valid=1, resp_error=1.
- r_v and w_v both 1: treated as write; no read data returned.
- strobe=0 with w_v=1: legal no-op write, normal write response.
- Neither r_v nor w_v: resp_valid=0, resp_error=0, resp=0.
- mem is not cleared by reset; contents persist across reset.

## Timing
- Fully pipelined: one request accepted every cycle, no stall, no back-pressure.
- Latency 1: request sampled at edge N; resp/resp_valid/resp_error valid after edge N, held for exactly one cycle unless a new request follows.
- Read-after-write same address on consecutive cycles: the read returns the newly written bytes (write commits at edge N, read sampled at edge N+1).
- Reset (rst_n=1 at edge): resp=0, resp_valid=0, resp_error=0 after the edge; any request in that cycle is dropped (no write performed). Reset mid-stream discards the pending response.
- Inputs are not registered beyond the single response stage; adr may change every cycle.

## Test plan
- Preload mem[0]=128'h44444444_33333333_22222222_11111111, base=32'h10000; read 0x10000, 0x10004, 0x1000C back-to-back → resp 0x11111111, 0x22222222, 0x44444444 on consecutive cycles, resp_valid=1 each, error 0.
- base=32'h20000: write 0xAABBCCDD strobe 4'b1111 to 0x20010, then write 0x000000EE strobe 4'b0001, then read → 0xAABBCCEE.
- Write 0x12345678 strobe 4'b0110 to word holding 0 → read 0x00345600.
- Read 0x1FFFC (below base) and base+size*16 → resp_valid=1, resp_error=1, resp=0; misaligned read 0x20002 → resp_error=1; out-of-range write leaves memory unchanged.
- r_v=1 tied high, adr sweeping 0x10000..0x1003C by 4 → 16 consecutive valid responses, no bubbles.
- Assert rst_n for one cycle during a write request → write not performed, outputs 0 after edge; previously preloaded data still readable after reset.
